// File: rtl/padovan_pkg.sv
// Shared widths, FSM encoding and recurrence seed for the Padovan term
// scheduler and its step engine.
package padovan_pkg;

   localparam int PADOVAN_W    = 16;
   localparam int PADOVAN_NW   = 16;
   localparam int PADOVAN_SEED = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/padovan_step_engine.sv
// Padovan recurrence engine: a=P(k), b=P(k-1), c=P(k-2), plus a sticky
// carry flag raised whenever a step's sum does not fit in W bits.
module padovan_step_engine
   import padovan_pkg::*;
#(
   parameter int W  = PADOVAN_W,
   parameter int NW = PADOVAN_NW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          step_i,
   output logic [W-1:0]  a_o,
   output logic [NW-1:0] k_o,
   output logic          ovf_o
);

   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  c_q, c_d;
   logic [NW-1:0] k_q, k_d;
   logic          ovf_q, ovf_d;
   logic [W:0]    sum;

   assign sum = {1'b0, b_q} + {1'b0, c_q};

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      c_d   = c_q;
      k_d   = k_q;
      ovf_d = ovf_q;
      if (load_i) begin
         a_d   = W'(PADOVAN_SEED);
         b_d   = W'(PADOVAN_SEED);
         c_d   = W'(PADOVAN_SEED);
         k_d   = NW'(2);
         ovf_d = 1'b0;
      end else if (step_i) begin
         a_d   = sum[W-1:0];
         b_d   = a_q;
         c_d   = b_q;
         k_d   = k_q + NW'(1);
         ovf_d = ovf_q | sum[W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         k_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         c_q   <= c_d;
         k_q   <= k_d;
         ovf_q <= ovf_d;
      end
   end

   assign a_o   = a_q;
   assign k_o   = k_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/padovan_term_scheduler.sv
// Round-robin scheduler sharing one Padovan engine among NREQ requesters.
// Define PADOVAN_SEQ_RESUME_EN to let a job continue from the last engine state.
module padovan_term_scheduler
   import padovan_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = PADOVAN_W,
   parameter int NW   = PADOVAN_NW,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*NW-1:0] req_n,
   output logic [NREQ-1:0]   req_ready,
   output logic              resp_valid,
   output logic [IDW-1:0]    resp_id,
   output logic [W-1:0]      resp_data,
   output logic              resp_ovf,
   input  logic              resp_ready,
   output logic              busy
);

   state_t         state_q, state_d;
   logic [IDW-1:0] rr_q, rr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [NW-1:0]  n_q, n_d;
`ifdef PADOVAN_SEQ_RESUME_EN
   logic           saved_q, saved_d;
`endif

   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic [NW-1:0]   gnt_n;
   logic            found;
   int              idx;

   logic            accept;
   logic            load;
   logic            step;
   logic [W-1:0]    eng_a;
   logic [NW-1:0]   eng_k;
   logic            eng_ovf;

   padovan_step_engine #(
      .W  (W),
      .NW (NW)
   ) u_engine (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .step_i (step),
      .a_o    (eng_a),
      .k_o    (eng_k),
      .ovf_o  (eng_ovf)
   );

   // first valid requester at or above the rr pointer, wrapping
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      gnt_n  = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
            gnt_n    = req_n[idx*NW +: NW];
         end
      end
   end

   assign req_ready = (state_q == IDLE) ? gnt : '0;
   assign accept    = |(req_valid & req_ready);

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      n_d     = n_q;
      load    = 1'b0;
      step    = 1'b0;
`ifdef PADOVAN_SEQ_RESUME_EN
      saved_d = saved_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               n_d     = gnt_n;
               id_d    = gnt_id;
               rr_d    = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
               state_d = RUN;
`ifdef PADOVAN_SEQ_RESUME_EN
               load    = !(saved_q && (gnt_n >= eng_k));
`else
               load    = 1'b1;
`endif
            end
         end
         RUN: begin
            if (eng_k >= n_q) state_d = RESP;
            else              step    = 1'b1;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
`ifdef PADOVAN_SEQ_RESUME_EN
               saved_d = !eng_ovf;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         n_q     <= '0;
`ifdef PADOVAN_SEQ_RESUME_EN
         saved_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         n_q     <= n_d;
`ifdef PADOVAN_SEQ_RESUME_EN
         saved_q <= saved_d;
`endif
      end
   end

   assign resp_valid = (state_q == RESP);
   assign resp_id    = resp_valid ? id_q : '0;
   assign resp_data  = resp_valid ? eng_a : '0;
   assign resp_ovf   = resp_valid ? eng_ovf : 1'b0;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_padovan_term_scheduler.sv
// Directed bench for padovan_term_scheduler: a W=16 and a W=8 instance
// share one stimulus stream; the W=8 copy exposes truncation and overflow.
module tb_padovan_term_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [63:0] req_n;
   logic        resp_ready;

   logic [3:0]  req_ready, req_ready8;
   logic        resp_valid, resp_valid8;
   logic [1:0]  resp_id, resp_id8;
   logic [15:0] resp_data;
   logic [7:0]  resp_data8;
   logic        resp_ovf, resp_ovf8;
   logic        busy, busy8;

   int n_chk = 0;
   int n_pass = 0;

   int          got_gid, got_lat, el;
   logic [15:0] got_d;
   logic [1:0]  got_id;
   logic        got_ovf, got_v8, got_ovf8;
   logic [7:0]  got_d8;

`ifdef PADOVAN_SEQ_RESUME_EN
   int m_k = 0;
   bit m_ok = 1'b0;
`endif

   always #5 clk = ~clk;

   padovan_term_scheduler #(.NREQ(4), .W(16), .NW(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
      .resp_data(resp_data), .resp_ovf(resp_ovf), .resp_ready(resp_ready),
      .busy(busy)
   );

   padovan_term_scheduler #(.NREQ(4), .W(8), .NW(16)) dut8 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
      .req_ready(req_ready8), .resp_valid(resp_valid8), .resp_id(resp_id8),
      .resp_data(resp_data8), .resp_ovf(resp_ovf8), .resp_ready(resp_ready),
      .busy(busy8)
   );

   // expected cycles from accept edge to resp_valid, tracking the W=16 DUT
   function automatic int exp_lat(input int n);
      int l;
      l = 1 + ((n > 2) ? n - 2 : 0);
`ifdef PADOVAN_SEQ_RESUME_EN
      if (m_ok && n >= m_k) begin
         l   = 1 + n - m_k;
         m_k = n;
      end else begin
         m_k = (n > 2) ? n : 2;
      end
      m_ok = 1'b1;
`endif
      return l;
   endfunction

   task automatic model_reset();
`ifdef PADOVAN_SEQ_RESUME_EN
      m_ok = 1'b0;
      m_k  = 0;
`endif
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      resp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic accept();
      got_gid = -1;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (req_ready != 4'b0) begin
            for (int j = 0; j < 4; j++) if (req_ready[j]) got_gid = j;
            @(posedge clk);
            #1;
            req_valid[got_gid] = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic collect(input bit ack);
      got_lat = 0;
      @(negedge clk);
      while (!resp_valid) begin
         if (got_lat >= 200) begin
            got_lat = -1;
            break;
         end
         @(negedge clk);
         got_lat++;
      end
      got_d    = resp_data;
      got_id   = resp_id;
      got_ovf  = resp_ovf;
      got_v8   = resp_valid8;
      got_d8   = resp_data8;
      got_ovf8 = resp_ovf8;
      if (ack) begin
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
      end
   endtask

   task automatic job(input int r, input int n);
      req_n[r*16 +: 16] = n[15:0];
      req_valid[r] = 1'b1;
      el = exp_lat(n);
      accept();
      collect(1'b1);
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_chk++;
      if ({resp_valid, resp_ovf, busy, resp_id, resp_data, req_ready} !== 25'd0)
         $display("FAIL reset.outs: got %h want 0",
                  {resp_valid, resp_ovf, busy, resp_id, resp_data, req_ready});
      else n_pass++;
      n_chk++;
      if ({resp_valid8, resp_ovf8, busy8, resp_id8, resp_data8} !== 13'd0)
         $display("FAIL reset.outs8: got %h want 0",
                  {resp_valid8, resp_ovf8, busy8, resp_id8, resp_data8});
      else n_pass++;
      req_valid = 4'b0110;
      #1;
      n_chk++;
      if (req_ready !== 4'b0010)
         $display("FAIL reset.arb_comb: got %b want 0010", req_ready);
      else n_pass++;
      req_valid = 4'b1000;
      #1;
      n_chk++;
      if (req_ready !== 4'b1000)
         $display("FAIL reset.arb_drop: got %b want 1000", req_ready);
      else n_pass++;
      req_valid = 4'b0000;
   endtask

   task automatic test_short();
      int r[2] = '{0, 1};
      int n[2] = '{0, 2};
      for (int i = 0; i < 2; i++) begin
         job(r[i], n[i]);
         n_chk++;
         if (got_gid !== r[i])
            $display("FAIL short%0d.gid: got %0d want %0d", i, got_gid, r[i]);
         else n_pass++;
         n_chk++;
         if (got_lat !== el)
            $display("FAIL short%0d.lat: got %0d want %0d", i, got_lat, el);
         else n_pass++;
         n_chk++;
         if ({got_id, got_ovf, got_d} !== {r[i][1:0], 1'b0, 16'd1})
            $display("FAIL short%0d.resp: got id=%0d ovf=%0d d=%0d want id=%0d ovf=0 d=1",
                     i, got_id, got_ovf, got_d, r[i]);
         else n_pass++;
      end
   endtask

   task automatic test_long();
      int r[2] = '{2, 3};
      int n[2] = '{10, 20};
      int d[2] = '{12, 200};
      for (int i = 0; i < 2; i++) begin
         job(r[i], n[i]);
         n_chk++;
         if (got_lat !== el)
            $display("FAIL long%0d.lat: got %0d want %0d", i, got_lat, el);
         else n_pass++;
         n_chk++;
         if ({got_id, got_ovf, got_d} !== {r[i][1:0], 1'b0, d[i][15:0]})
            $display("FAIL long%0d.resp: got id=%0d ovf=%0d d=%0d want id=%0d ovf=0 d=%0d",
                     i, got_id, got_ovf, got_d, r[i], d[i]);
         else n_pass++;
      end
   endtask

   task automatic test_rr();
      int gid[8] = '{0, 1, 2, 3, 0, 3, 0, 1};
      int nn[8]  = '{3, 4, 5, 6, 5, 7, 8, 9};
      int dd[8]  = '{2, 2, 3, 4, 3, 5, 7, 9};
      for (int i = 0; i < 4; i++) req_n[i*16 +: 16] = 16'(nn[i]);
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            req_n[0 +: 16]  = 16'd5;
            req_n[48 +: 16] = 16'd7;
            req_valid = 4'b1001;
         end
         if (i == 6) begin
            req_n[0 +: 16]  = 16'd8;
            req_n[16 +: 16] = 16'd9;
            req_valid = 4'b0011;
         end
         el = exp_lat(nn[i]);
         accept();
         collect(1'b1);
         n_chk++;
         if (got_gid !== gid[i])
            $display("FAIL rr%0d.gid: got %0d want %0d", i, got_gid, gid[i]);
         else n_pass++;
         n_chk++;
         if (got_lat !== el)
            $display("FAIL rr%0d.lat: got %0d want %0d", i, got_lat, el);
         else n_pass++;
         n_chk++;
         if ({got_id, got_d} !== {gid[i][1:0], dd[i][15:0]})
            $display("FAIL rr%0d.resp: got id=%0d d=%0d want id=%0d d=%0d",
                     i, got_id, got_d, gid[i], dd[i]);
         else n_pass++;
      end
   endtask

   task automatic test_width8();
      job(0, 20);
      n_chk++;
      if ({got_v8, got_ovf8, got_d8} !== {1'b1, 1'b0, 8'd200})
         $display("FAIL w8.n20: got v=%0d ovf=%0d d=%0d want v=1 ovf=0 d=200",
                  got_v8, got_ovf8, got_d8);
      else n_pass++;
      job(1, 21);
      n_chk++;
      if ({got_v8, got_ovf8, got_d8} !== {1'b1, 1'b1, 8'd9})
         $display("FAIL w8.n21: got v=%0d ovf=%0d d=%0d want v=1 ovf=1 d=9",
                  got_v8, got_ovf8, got_d8);
      else n_pass++;
      n_chk++;
      if ({got_ovf, got_d} !== {1'b0, 16'd265})
         $display("FAIL w16.n21: got ovf=%0d d=%0d want ovf=0 d=265", got_ovf, got_d);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_backpressure();
      req_n[0 +: 16] = 16'd6;
      req_valid[0] = 1'b1;
      el = exp_lat(6);
      accept();
      collect(1'b0);
      n_chk++;
      if (got_lat !== el)
         $display("FAIL bp.lat: got %0d want %0d", got_lat, el);
      else n_pass++;
      req_n[16 +: 16] = 16'd3;
      req_valid[1] = 1'b1;
      #1;
      n_chk++;
      if (req_ready !== 4'b0000)
         $display("FAIL bp.ready_in_resp: got %b want 0000", req_ready);
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_chk++;
         if ({resp_valid, resp_id, resp_data, req_ready} !== {1'b1, 2'd0, 16'd4, 4'd0})
            $display("FAIL bp.hold%0d: got v=%0d id=%0d d=%0d rdy=%b want v=1 id=0 d=4 rdy=0000",
                     c, resp_valid, resp_id, resp_data, req_ready);
         else n_pass++;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      n_chk++;
      if ({busy, req_ready} !== 5'b0_0010)
         $display("FAIL bp.after_hs: got busy=%0d rdy=%b want busy=0 rdy=0010",
                  busy, req_ready);
      else n_pass++;
      el = exp_lat(3);
      accept();
      collect(1'b1);
      n_chk++;
      if ({got_gid, got_lat, got_d} !== {32'sd1, el, 16'd2})
         $display("FAIL bp.req1: got gid=%0d lat=%0d d=%0d want gid=1 lat=%0d d=2",
                  got_gid, got_lat, got_d, el);
      else n_pass++;
   endtask

   task automatic test_abort();
      bit seen;
      int r[4] = '{2, 0, 1, 3};
      int n[4] = '{4, 10, 12, 5};
      int d[4] = '{2, 12, 21, 3};
      req_n[0 +: 16] = 16'd100;
      req_valid[0] = 1'b1;
      accept();
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({resp_valid, resp_ovf, busy, resp_id, resp_data, req_ready} !== 25'd0)
         $display("FAIL abort.outs: got %h want 0",
                  {resp_valid, resp_ovf, busy, resp_id, resp_data, req_ready});
      else n_pass++;
      rst = 1'b1;
      model_reset();
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (resp_valid || busy) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0)
         $display("FAIL abort.no_resp: got activity=%0d want 0", seen);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         job(r[i], n[i]);
         n_chk++;
         if ({got_gid, got_lat} !== {r[i], el})
            $display("FAIL abort%0d.gid_lat: got gid=%0d lat=%0d want gid=%0d lat=%0d",
                     i, got_gid, got_lat, r[i], el);
         else n_pass++;
         n_chk++;
         if ({got_id, got_d} !== {r[i][1:0], d[i][15:0]})
            $display("FAIL abort%0d.resp: got id=%0d d=%0d want id=%0d d=%0d",
                     i, got_id, got_d, r[i], d[i]);
         else n_pass++;
`ifdef PADOVAN_SEQ_RESUME_EN
         if (i == 2) begin
            n_chk++;
            if (got_lat !== 3)
               $display("FAIL resume.run_len: got %0d want 3", got_lat);
            else n_pass++;
         end
`endif
      end
   endtask

   initial begin
      rst = 1'b0;
      req_valid = '0;
      req_n = '0;
      resp_ready = 1'b0;
      test_reset();
      test_short();
      test_long();
      test_rr();
      test_width8();
      test_backpressure();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
